// File: rtl/sifh_hist_fsm_pkg.sv
// rtl/sifh_hist_fsm_pkg.sv - shared parameters, state encoding and helpers for the histogrammer
package sifh_hist_fsm_pkg;

    localparam int Np                = 10;
    localparam int peakMax           = 8;
    localparam int PIXEL_NUM         = 2;
    localparam int ACQ_NUM           = 2;
    localparam int DATA_NUM          = 3;
    localparam int PIXEL_NUM_PER_RAM = 2;
    localparam int HIST_BITS         = 6;
    localparam int RAM_ADDR          = $clog2(PIXEL_NUM_PER_RAM) + HIST_BITS;

    localparam int SLOT_WORDS = DATA_NUM * 2;
    localparam int TOTAL      = PIXEL_NUM * ACQ_NUM * SLOT_WORDS;
    localparam int CNT_W      = $clog2(TOTAL + 1);
    localparam int SLOT_W     = (SLOT_WORDS > 1) ? $clog2(SLOT_WORDS) : 1;
    localparam int PIX_W      = (PIXEL_NUM > 1) ? $clog2(PIXEL_NUM) : 1;

    localparam logic [Np-1:0]      NO_EVENT = '1;
    localparam logic [peakMax-1:0] CNT_MAX  = '1;

    typedef enum logic [1:0] {
        ST_START = 2'd0,
        ST_ACC   = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    function automatic logic [peakMax-1:0] sat_inc(input logic [peakMax-1:0] v);
        return (v == CNT_MAX) ? v : v + peakMax'(1);
    endfunction

endpackage

// File: rtl/sifh_rmw_pipe.sv
// rtl/sifh_rmw_pipe.sv - two-stage read-modify-write pipeline with saturating increment and forwarding
module sifh_rmw_pipe
    import sifh_hist_fsm_pkg::*;
(
    input  logic                clk_i,
    input  logic                rst_n_i,
    input  logic                take_i,
    input  logic                valid_i,
    input  logic [RAM_ADDR-1:0] addr_i,
    input  logic [peakMax-1:0]  counts_i,
    output logic [RAM_ADDR-1:0] raddr_o,
    output logic                ren_n_o,
    output logic                rflag_o,
    output logic [RAM_ADDR-1:0] waddr_o,
    output logic                wen_o,
    output logic                wflag_o,
    output logic [peakMax-1:0]  new_counts_o
);

    logic                rd_q, rd_d;
    logic [RAM_ADDR-1:0] raddr_q, raddr_d;
    logic                wr_q, wr_d;
    logic [RAM_ADDR-1:0] waddr_q, waddr_d;
    logic                fwd_valid_q, fwd_valid_d;
    logic [RAM_ADDR-1:0] fwd_addr_q, fwd_addr_d;
    logic [peakMax-1:0]  fwd_cnt_q, fwd_cnt_d;
    logic [peakMax-1:0]  base;
    logic [peakMax-1:0]  new_counts;

    // The RAM returns stale data when our read shares an edge with the previous write.
    always_comb begin
        base = counts_i;
        if (fwd_valid_q && wr_q && (fwd_addr_q == waddr_q)) begin
            base = fwd_cnt_q;
        end
        new_counts = wr_q ? sat_inc(base) : '0;
    end

    always_comb begin
        rd_d        = take_i && valid_i;
        raddr_d     = (take_i && valid_i) ? addr_i : raddr_q;
        wr_d        = rd_q;
        waddr_d     = rd_q ? raddr_q : waddr_q;
        fwd_valid_d = wr_q;
        fwd_addr_d  = waddr_q;
        fwd_cnt_d   = new_counts;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rd_q        <= 1'b0;
            raddr_q     <= '0;
            wr_q        <= 1'b0;
            waddr_q     <= '0;
            fwd_valid_q <= 1'b0;
            fwd_addr_q  <= '0;
            fwd_cnt_q   <= '0;
        end else begin
            rd_q        <= rd_d;
            raddr_q     <= raddr_d;
            wr_q        <= wr_d;
            waddr_q     <= waddr_d;
            fwd_valid_q <= fwd_valid_d;
            fwd_addr_q  <= fwd_addr_d;
            fwd_cnt_q   <= fwd_cnt_d;
        end
    end

    assign raddr_o      = raddr_q;
    assign ren_n_o      = !rd_q;
    assign rflag_o      = rd_q;
    assign waddr_o      = waddr_q;
    assign wen_o        = wr_q;
    assign wflag_o      = wr_q;
    assign new_counts_o = new_counts;

endmodule

// File: rtl/sifh_hist_fsm.sv
// rtl/sifh_hist_fsm.sv - acquisition FSM, word counting and bin address mapping for the histogrammer
module sifh_hist_fsm
    import sifh_hist_fsm_pkg::*;
(
    input  logic                clk,
    input  logic                res,
    input  logic [Np-1:0]       data,
    input  logic [peakMax-1:0]  counts,
    output logic                wrEn,
    output logic [RAM_ADDR-1:0] raddr,
    output logic                rEnable,
    output logic                readFlag,
    output logic [RAM_ADDR-1:0] waddr,
    output logic                wEnable,
    output logic                writeFlag,
    output logic [peakMax-1:0]  newCounts
);

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [SLOT_W-1:0]   wsl_q, wsl_d;
    logic [PIX_W-1:0]    pix_q, pix_d;
    logic                take;
    logic                word_valid;
    logic [HIST_BITS-1:0] bin;
    logic [RAM_ADDR-1:0] addr;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wsl_d   = wsl_q;
        pix_d   = pix_q;
        take    = 1'b0;
        case (state_q)
            ST_START: state_d = ST_ACC;
            ST_ACC: begin
                take  = 1'b1;
                cnt_d = cnt_q + CNT_W'(1);
                // Slot words roll into the next pixel; pixels roll into the next acquisition.
                if (wsl_q == SLOT_W'(SLOT_WORDS - 1)) begin
                    wsl_d = '0;
                    pix_d = (pix_q == PIX_W'(PIXEL_NUM - 1)) ? '0 : pix_q + PIX_W'(1);
                end else begin
                    wsl_d = wsl_q + SLOT_W'(1);
                end
                if (cnt_q == CNT_W'(TOTAL - 1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_DONE;
            default: state_d = ST_START;
        endcase
    end

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            state_q <= ST_START;
            cnt_q   <= '0;
            wsl_q   <= '0;
            pix_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wsl_q   <= wsl_d;
            pix_q   <= pix_d;
        end
    end

    assign wrEn       = (state_q != ST_DONE);
    assign word_valid = (data != NO_EVENT);
    assign bin        = data[Np-1 -: HIST_BITS];
    assign addr       = RAM_ADDR'((32'(pix_q) % PIXEL_NUM_PER_RAM) << HIST_BITS) + RAM_ADDR'(bin);

    sifh_rmw_pipe u_pipe (
        .clk_i        (clk),
        .rst_n_i      (res),
        .take_i       (take),
        .valid_i      (word_valid),
        .addr_i       (addr),
        .counts_i     (counts),
        .raddr_o      (raddr),
        .ren_n_o      (rEnable),
        .rflag_o      (readFlag),
        .waddr_o      (waddr),
        .wen_o        (wEnable),
        .wflag_o      (writeFlag),
        .new_counts_o (newCounts)
    );

endmodule

// File: tb/tb_sifh_hist_fsm.sv
// tb/tb_sifh_hist_fsm.sv - directed table-driven bench for the histogrammer control FSM
module tb_sifh_hist_fsm;

    logic       clk = 1'b0;
    logic       res;
    logic [9:0] data;
    logic [7:0] counts;
    logic       wrEn, rEnable, readFlag, wEnable, writeFlag;
    logic [6:0] raddr, waddr;
    logic [7:0] newCounts;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [9:0] d;
        logic [7:0] c;
        logic       wr;
        logic       rf;
        logic [6:0] ra;
        logic       we;
        logic [6:0] wa;
        logic [7:0] nc;
    } vec_t;

    vec_t tv [28];

    always #5 clk = ~clk;

    sifh_hist_fsm dut (
        .clk       (clk),
        .res       (res),
        .data      (data),
        .counts    (counts),
        .wrEn      (wrEn),
        .raddr     (raddr),
        .rEnable   (rEnable),
        .readFlag  (readFlag),
        .waddr     (waddr),
        .wEnable   (wEnable),
        .writeFlag (writeFlag),
        .newCounts (newCounts)
    );

    function automatic vec_t mk(int d, int c, int wr, int rf, int ra, int we, int wa, int nc);
        vec_t v;
        v.d  = 10'(d);
        v.c  = 8'(c);
        v.wr = 1'(wr);
        v.rf = 1'(rf);
        v.ra = 7'(ra);
        v.we = 1'(we);
        v.wa = 7'(wa);
        v.nc = 8'(nc);
        return v;
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s step %0d got %0d want %0d", name, idx, act, exp);
        end
    endtask

    initial begin
        // Row n: data for the word sampled at the next edge, counts for the current write slot,
        // expected outputs after edge n (edge 0 is the START edge).
        tv[0]  = mk(108,  77, 1, 0,   0, 0,   0,   0);
        tv[1]  = mk(1023, 77, 1, 1,   6, 0,   0,   0);
        tv[2]  = mk(1023,  0, 1, 0,   6, 1,   6,   1);
        tv[3]  = mk(1023, 77, 1, 0,   6, 0,   6,   0);
        tv[4]  = mk(1023, 77, 1, 0,   6, 0,   6,   0);
        tv[5]  = mk(1023, 77, 1, 0,   6, 0,   6,   0);
        tv[6]  = mk(600,  77, 1, 0,   6, 0,   6,   0);
        tv[7]  = mk(1023, 77, 1, 1, 101, 0,   6,   0);
        tv[8]  = mk(1023,  5, 1, 0, 101, 1, 101,   6);
        tv[9]  = mk(1023, 77, 1, 0, 101, 0, 101,   0);
        tv[10] = mk(1023, 77, 1, 0, 101, 0, 101,   0);
        tv[11] = mk(1023, 77, 1, 0, 101, 0, 101,   0);
        tv[12] = mk(511,  77, 1, 0, 101, 0, 101,   0);
        tv[13] = mk(511,  77, 1, 1,  31, 0, 101,   0);
        tv[14] = mk(1023,  0, 1, 1,  31, 1,  31,   1);
        tv[15] = mk(511,   0, 1, 0,  31, 1,  31,   2);
        tv[16] = mk(1023, 77, 1, 1,  31, 0,  31,   0);
        tv[17] = mk(1023, 255, 1, 0, 31, 1,  31, 255);
        tv[18] = mk(1023, 77, 1, 0,  31, 0,  31,   0);
        tv[19] = mk(1023, 77, 1, 0,  31, 0,  31,   0);
        tv[20] = mk(1023, 77, 1, 0,  31, 0,  31,   0);
        tv[21] = mk(1023, 77, 1, 0,  31, 0,  31,   0);
        tv[22] = mk(1023, 77, 1, 0,  31, 0,  31,   0);
        tv[23] = mk(600,  77, 1, 0,  31, 0,  31,   0);
        tv[24] = mk(108,  77, 0, 1, 101, 0,  31,   0);
        tv[25] = mk(108,   9, 0, 0, 101, 1, 101,  10);
        tv[26] = mk(108,  77, 0, 0, 101, 0, 101,   0);
        tv[27] = mk(108,  77, 0, 0, 101, 0, 101,   0);

        res    = 1'b0;
        data   = 10'd108;
        counts = 8'd77;
        #2;
        chk("rst_wrEn", -1, 32'(wrEn), 1);
        chk("rst_rEnable", -1, 32'(rEnable), 1);
        chk("rst_readFlag", -1, 32'(readFlag), 0);
        chk("rst_wEnable", -1, 32'(wEnable), 0);
        chk("rst_writeFlag", -1, 32'(writeFlag), 0);
        chk("rst_raddr", -1, 32'(raddr), 0);
        chk("rst_waddr", -1, 32'(waddr), 0);
        chk("rst_newCounts", -1, 32'(newCounts), 0);
        #1 res = 1'b1;
        #1 chk("rel_wrEn", -1, 32'(wrEn), 1);

        for (int i = 0; i < 28; i++) begin
            @(posedge clk);
            #1;
            data   = tv[i].d;
            counts = tv[i].c;
            #1;
            chk("wrEn", i, 32'(wrEn), 32'(tv[i].wr));
            chk("readFlag", i, 32'(readFlag), 32'(tv[i].rf));
            chk("rEnable", i, 32'(rEnable), 32'(!tv[i].rf));
            chk("raddr", i, 32'(raddr), 32'(tv[i].ra));
            chk("wEnable", i, 32'(wEnable), 32'(tv[i].we));
            chk("writeFlag", i, 32'(writeFlag), 32'(tv[i].we));
            chk("waddr", i, 32'(waddr), 32'(tv[i].wa));
            chk("newCounts", i, 32'(newCounts), 32'(tv[i].nc));
        end

        // Reset taken between the read and the write must flush the pending write.
        res = 1'b0;
        #1;
        chk("rst2_wrEn", 100, 32'(wrEn), 1);
        chk("rst2_wEnable", 100, 32'(wEnable), 0);
        res    = 1'b1;
        data   = 10'd108;
        counts = 8'd77;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        chk("mid_readFlag", 101, 32'(readFlag), 1);
        chk("mid_raddr", 101, 32'(raddr), 6);
        res = 1'b0;
        #1;
        chk("mid_rst_readFlag", 102, 32'(readFlag), 0);
        chk("mid_rst_rEnable", 102, 32'(rEnable), 1);
        chk("mid_rst_raddr", 102, 32'(raddr), 0);
        res = 1'b1;
        @(posedge clk);
        #1;
        chk("flush_wEnable", 103, 32'(wEnable), 0);
        chk("flush_writeFlag", 103, 32'(writeFlag), 0);
        chk("flush_readFlag", 103, 32'(readFlag), 0);
        @(posedge clk);
        #1;
        chk("rerun_readFlag", 104, 32'(readFlag), 1);
        counts = 8'd3;
        @(posedge clk);
        #1;
        chk("rerun_wEnable", 105, 32'(wEnable), 1);
        chk("rerun_waddr", 105, 32'(waddr), 6);
        chk("rerun_newCounts", 105, 32'(newCounts), 4);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/sifh_hist_fsm.md
Name: sifh_hist_fsm

Overview:
Control FSM for the single-photon time-of-flight histogrammer.
- Accepts a stream of Np-bit timestamps, one per clock, and maps each to a histogram bin address in the per-pixel histogram RAM.
- Does a pipelined read-modify-write (count+1, saturating) on an external dual-port RAM: port a writes, port b reads with 1-cycle synchronous read.
- Sits between the timestamp source (TDC/serialiser) and the histogram RAM. Peak extraction is downstream and out of scope.

Parameters:
Np, 10, timestamp width; all-ones (1023) = no event.
peakMax, 8, histogram count width.
PIXEL_NUM, 2, pixels in the stream.
ACQ_NUM, 2, acquisitions (frames) per run.
DATA_NUM, 3, timestamp slots per pixel per acquisition; each slot carries 2 words.
PIXEL_NUM_PER_RAM, 2, pixel histograms held in one RAM; equals PIXEL_NUM by default.
HIST_BITS, 6, bin index = data[Np-1 -: HIST_BITS].
RAM_ADDR, 7, clog2(PIXEL_NUM_PER_RAM)+HIST_BITS.

Ports:
clk  in  1  system clock, rising edge.
res  in  1  reset, asynchronous, active-low.
data  in  Np  timestamp word, sampled on rising clk while accepting.
counts  in  peakMax  RAM port-b read data, valid the cycle after the read.
wrEn  out  1  ready/accepting input words.
raddr  out  RAM_ADDR  port-b read address.
rEnable  out  1  port-b enable, active-low.
readFlag  out  1  port-b memory enable (meb), active-high.
waddr  out  RAM_ADDR  port-a write address.
wEnable  out  1  port-a write enable, active-high.
writeFlag  out  1  port-a memory enable (mea), active-high.
newCounts  out  peakMax  port-a write data.

Behaviour:
Reset values (res=0, async):
- state=START, wrEn=1, word counter=0.
- raddr=0, waddr=0, newCounts=0, rEnable=1, readFlag=0, wEnable=0, writeFlag=0.

States:
- START: wrEn=1; data is not sampled; the next edge moves to ACC.
- ACC: wrEn=1; each edge samples data and increments the word counter.
- After TOTAL = PIXEL_NUM*ACQ_NUM*DATA_NUM*2 words have been sampled, the next state is DONE.
- DONE: wrEn=0; further data is ignored; the pipeline drains. State held until reset.

Word ordering (index i, 0-based):
- acquisition outermost, then pixel, then slot, then word within slot.
- pixel = (i / (DATA_NUM*2)) mod PIXEL_NUM.
- addr = (pixel mod PIXEL_NUM_PER_RAM)*2^HIST_BITS + data[Np-1 -: HIST_BITS].

Pipeline:
- Stage 1, registered at the sampling edge. If the word is valid (data != all-ones):
  - raddr=addr, readFlag=1, rEnable=0 for one cycle.
  - Invalid words: readFlag=0, rEnable=1; no RAM activity, but the word still counts toward TOTAL.
- Stage 2, the next cycle:
  - waddr = stage-1 addr (registered), wEnable=1, writeFlag=1.
  - newCounts = base+1, saturating at 2^peakMax-1 (never wraps).
  - The RAM latches the write at the following edge.
  - When stage 2 is empty: wEnable=0, writeFlag=0, newCounts=0.
- Hazard: the RAM returns old data on a same-edge read/write.
  - If the previous stage-2 item was valid with the same address, base = the registered previous newCounts; otherwise base = counts.
  - Distance ≥2 needs no forwarding.
- Latency: 2 cycles from sampling to write. At most one read and one write per cycle.
- Reset mid-run: pipeline flushed, no write issued. RAM contents are not cleared (clearing is external).

Decomposition:
- Shared package/header (parametersSiFH): Np, peakMax, PIXEL_NUM, ACQ_NUM, DATA_NUM, PIXEL_NUM_PER_RAM, HIST_BITS, RAM_ADDR, the no-event constant, and the state encoding.
- One natural sub-module, sifh_rmw_pipe: stage registers, saturating incrementer, forwarding.
- The FSM/counter/address mapping stays in the top.

Test Plan:
- Release reset -> wrEn=1 before any clock edge. The first edge is START and samples nothing; wrEn stays 1.
- Pixel 0, data=108 with counts=0 returned -> raddr=6, rEnable=0, readFlag=1; next cycle waddr=6, newCounts=1, wEnable=writeFlag=1.
- Pixel 0, data=1023 -> no read or write strobes; word counter still advances.
- Words 6..11 (pixel 1), data=600, counts=5 -> raddr=waddr=101, newCounts=6.
- Back-to-back data=511,511 with the RAM returning 0 both times -> writes at addr 31: newCounts=1 then 2 (forwarded). Also: counts=255 -> newCounts=255.
- Stream TOTAL=24 words then 3 extra -> wrEn=0 the cycle after word 24; last write issued; extra words cause no strobes.
